// File: rtl/lw_sha_round_ctrl.sv
// lw_sha_round_ctrl: sequences masked SHA-256/512 compression rounds through the
// combinational lw_sha_round datapath, one round per accepted schedule word.
`default_nettype none

`ifndef WORD_SIZE
  `ifdef CORE_ARCH_S32
    `define WORD_SIZE 32
  `else
    `define WORD_SIZE 64
  `endif
`endif

module lw_sha_round_ctrl (
  input  logic                        clk_i,
  input  logic                        rst_ni,
`ifndef CORE_ARCH_S32
  input  logic                        mode_i,
`endif
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [7:0][`WORD_SIZE:0]    init_state_i,
  input  logic [`WORD_SIZE-1:0]       word_i,
  input  logic                        word_valid_i,
  output logic                        word_ready_o,
  input  logic [1:0]                  rnd_i,
  output logic [7:0][`WORD_SIZE:0]    rnd_state_o,
  output logic [`WORD_SIZE-1:0]       rnd_word_o,
  output logic [6:0]                  rnd_index_o,
  output logic [1:0]                  rnd_random_o,
  output logic                        rnd_mode_o,
  input  logic [7:0][`WORD_SIZE:0]    rnd_new_state_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [7:0][`WORD_SIZE:0]    state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [6:0] LAST_256 = 7'd63;
  localparam logic [6:0] LAST_512 = 7'd79;

  logic [1:0]                 fsm_q, fsm_d;
  logic [6:0]                 idx_q, idx_d;
  logic                       mode_q, mode_d;
  logic [7:0][`WORD_SIZE:0]   state_q, state_d;
  logic                       mode_in;
  logic                       fire;
  logic [6:0]                 last_idx;

`ifdef CORE_ARCH_S32
  assign mode_in = 1'b0;
`else
  assign mode_in = mode_i;
`endif

  assign last_idx = mode_q ? LAST_512 : LAST_256;
  // Abort suppresses consumption so the scheduler never loses a word to a cancelled round.
  assign fire     = (fsm_q == ST_RUN) && word_valid_i && !abort_i;

  always_comb begin
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          fsm_d   = ST_RUN;
          idx_d   = 7'd0;
          mode_d  = mode_in;
          state_d = init_state_i;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          fsm_d = ST_IDLE;
        end else if (fire) begin
          state_d = rnd_new_state_i;
          if (idx_q == last_idx) begin
            fsm_d = ST_DONE;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= ST_IDLE;
      idx_q   <= 7'd0;
      mode_q  <= 1'b0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      state_q <= state_d;
    end
  end

  assign word_ready_o = (fsm_q == ST_RUN) && !abort_i;
  assign rnd_state_o  = state_q;
  assign rnd_word_o   = word_i;
  assign rnd_index_o  = idx_q;
  assign rnd_random_o = fire ? rnd_i : 2'b00;
  assign rnd_mode_o   = mode_q;
  assign busy_o       = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
  assign done_o       = (fsm_q == ST_DONE) && !abort_i;
  assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_lw_sha_round_ctrl.sv
// Directed bench for lw_sha_round_ctrl with a simple arithmetic stand-in for the round datapath.
`default_nettype none

`ifndef WORD_SIZE
  `define WORD_SIZE 64
`endif

module tb_lw_sha_round_ctrl;

  localparam int WS = `WORD_SIZE;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                mode_i = 1'b0;
  logic                start_i = 1'b0;
  logic                abort_i = 1'b0;
  logic [7:0][WS:0]    init_state_i;
  logic [WS-1:0]       word_i;
  logic                word_valid_i = 1'b0;
  logic                word_ready_o;
  logic [1:0]          rnd_i = 2'b00;
  logic [7:0][WS:0]    rnd_state_o;
  logic [WS-1:0]       rnd_word_o;
  logic [6:0]          rnd_index_o;
  logic [1:0]          rnd_random_o;
  logic                rnd_mode_o;
  logic [7:0][WS:0]    rnd_new_state_i;
  logic                busy_o;
  logic                done_o;
  logic [7:0][WS:0]    state_o;

  int total = 0;
  int bad   = 0;

  lw_sha_round_ctrl dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .mode_i          (mode_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .init_state_i    (init_state_i),
    .word_i          (word_i),
    .word_valid_i    (word_valid_i),
    .word_ready_o    (word_ready_o),
    .rnd_i           (rnd_i),
    .rnd_state_o     (rnd_state_o),
    .rnd_word_o      (rnd_word_o),
    .rnd_index_o     (rnd_index_o),
    .rnd_random_o    (rnd_random_o),
    .rnd_mode_o      (rnd_mode_o),
    .rnd_new_state_i (rnd_new_state_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .state_o         (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in round: a += W[t] + t, h += random; other words pass through.
  always_comb begin
    rnd_new_state_i    = rnd_state_o;
    rnd_new_state_i[7] = rnd_state_o[7] + {1'b0, rnd_word_o} + {{(WS-6){1'b0}}, rnd_index_o};
    rnd_new_state_i[0] = rnd_state_o[0] + {{(WS-1){1'b0}}, rnd_random_o};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Starts a block at the current negedge and returns at the negedge where done_o is seen.
  task automatic run_block(input logic m, input bit do_stall, input bit do_rnd, input bit hold_start,
                           output int lat, output int stalls, output int seqerr,
                           output logic [WS:0] rsum, output int fires);
    logic       v;
    logic [1:0] r;
    lat = 0; stalls = 0; seqerr = 0; rsum = '0; fires = 0;
    mode_i  = m;
    start_i = 1'b1;
    word_valid_i = 1'b0;
    @(negedge clk_i);
    if (!hold_start) start_i = 1'b0;
    for (int k = 0; k < 400; k++) begin
      lat++;
      if (done_o) break;
      if (hold_start && k == 30) mode_i = ~m;
      v = do_stall ? ((k % 10) >= 3) : 1'b1;
      r = do_rnd ? 2'($urandom_range(0, 3)) : 2'b00;
      word_valid_i = v;
      rnd_i = r;
      #1;
      if (word_ready_o) begin
        if (rnd_index_o != 7'(fires)) seqerr++;
        if (rnd_mode_o != m) seqerr++;
        if (rnd_random_o != (v ? r : 2'b00)) seqerr++;
        if (v) begin
          fires++;
          rsum = rsum + {{(WS-1){1'b0}}, r};
        end else begin
          stalls++;
        end
      end
      @(negedge clk_i);
    end
    word_valid_i = 1'b0;
    rnd_i = 2'b00;
  endtask

  localparam logic [64:0] A0      = 65'h0_6a09e667f3bcc908;
  localparam logic [64:0] G0      = 65'h0_1f83d9abfb41bd6b;
  localparam logic [64:0] H0      = 65'h0_5be0cd19137e2179;
  localparam logic [64:0] A_256   = 65'h0_6a09e667f3bcd128;  // A0 + 64 + sum(0..63)
  localparam logic [64:0] A_512   = 65'h0_6a09e667f3bcd5b0;  // A0 + 80 + sum(0..79)
  localparam logic [64:0] A_AB20  = 65'h0_6a09e667f3bcc9da;  // A0 + 20 + sum(0..19)

  int          lat, stalls, seqerr, fires, guard, late_done;
  logic [WS:0] rsum;

  initial begin
    init_state_i = {A0, 65'h0_bb67ae8584caa73b, 65'h0_3c6ef372fe94f82b, 65'h0_a54ff53a5f1d36f1,
                    65'h0_510e527fade682d1, 65'h0_9b05688c2b3e6c1f, G0, H0};
    word_i = 64'd1;

    #12;
    chk("rst_busy",   128'(busy_o), 128'd0);
    chk("rst_done",   128'(done_o), 128'd0);
    chk("rst_ready",  128'(word_ready_o), 128'd0);
    chk("rst_random", 128'(rnd_random_o), 128'd0);
    chk("rst_state",  128'(state_o != '0), 128'd0);
    chk("rst_index",  128'(rnd_index_o), 128'd0);
    chk("rst_mode",   128'(rnd_mode_o), 128'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_block(1'b0, 1'b0, 1'b0, 1'b0, lat, stalls, seqerr, rsum, fires);
    chk("b256_lat",   128'(lat), 128'd65);
    chk("b256_fires", 128'(fires), 128'd64);
    chk("b256_seq",   128'(seqerr), 128'd0);
    chk("b256_a",     128'(state_o[7]), 128'(A_256));
    chk("b256_g",     128'(state_o[1]), 128'(G0));
    chk("b256_h",     128'(state_o[0]), 128'(H0));
    @(negedge clk_i);
    chk("b256_idle",  128'(busy_o), 128'd0);
    chk("b256_pulse", 128'(done_o), 128'd0);
    chk("b256_hold",  128'(state_o[7]), 128'(A_256));

    run_block(1'b0, 1'b1, 1'b1, 1'b0, lat, stalls, seqerr, rsum, fires);
    chk("stall_lat",  128'(lat), 128'(65 + stalls));
    chk("stall_some", 128'(stalls > 0), 128'd1);
    chk("stall_seq",  128'(seqerr), 128'd0);
    chk("stall_a",    128'(state_o[7]), 128'(A_256));
    chk("stall_h",    128'(state_o[0]), 128'(H0 + rsum));
    @(negedge clk_i);

    run_block(1'b1, 1'b0, 1'b1, 1'b0, lat, stalls, seqerr, rsum, fires);
    chk("b512_lat",   128'(lat), 128'd81);
    chk("b512_fires", 128'(fires), 128'd80);
    chk("b512_seq",   128'(seqerr), 128'd0);
    chk("b512_a",     128'(state_o[7]), 128'(A_512));
    chk("b512_h",     128'(state_o[0]), 128'(H0 + rsum));
    @(negedge clk_i);

    // Abort once round 20 is presented.
    mode_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    guard = 0;
    word_valid_i = 1'b1;
    while (!(word_ready_o && rnd_index_o == 7'd20) && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    chk("abort_reach", 128'(guard < 100), 128'd1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    word_valid_i = 1'b0;
    chk("abort_busy",  128'(busy_o), 128'd0);
    chk("abort_ready", 128'(word_ready_o), 128'd0);
    chk("abort_state", 128'(state_o[7]), 128'(A_AB20));
    late_done = 0;
    for (int k = 0; k < 5; k++) begin
      if (done_o) late_done++;
      @(negedge clk_i);
    end
    chk("abort_nodone", 128'(late_done), 128'd0);
    run_block(1'b0, 1'b0, 1'b0, 1'b0, lat, stalls, seqerr, rsum, fires);
    chk("after_ab_lat", 128'(lat), 128'd65);
    chk("after_ab_a",   128'(state_o[7]), 128'(A_256));
    @(negedge clk_i);

    // Asynchronous reset pulse at round 40.
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    guard = 0;
    word_valid_i = 1'b1;
    while (!(word_ready_o && rnd_index_o == 7'd40) && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    chk("rst40_reach", 128'(guard < 100), 128'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst40_busy",  128'(busy_o), 128'd0);
    chk("rst40_ready", 128'(word_ready_o), 128'd0);
    chk("rst40_rand",  128'(rnd_random_o), 128'd0);
    chk("rst40_index", 128'(rnd_index_o), 128'd0);
    chk("rst40_state", 128'(state_o != '0), 128'd0);
    #1;
    rst_ni = 1'b1;
    word_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst40_idle",  128'(busy_o | done_o), 128'd0);

    // start held high; mode flips mid-block.
    run_block(1'b0, 1'b0, 1'b0, 1'b1, lat, stalls, seqerr, rsum, fires);
    chk("hold_lat",  128'(lat), 128'd65);
    chk("hold_seq",  128'(seqerr), 128'd0);
    chk("hold_a",    128'(state_o[7]), 128'(A_256));
    @(negedge clk_i);
    chk("hold_gap",  128'(busy_o), 128'd0);
    @(negedge clk_i);
    chk("hold_rerun", 128'(word_ready_o), 128'd1);
    chk("hold_mode2", 128'(rnd_mode_o), 128'd1);
    chk("hold_idx2",  128'(rnd_index_o), 128'd0);
    start_i = 1'b0;
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("final_idle", 128'(busy_o), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/lw_sha_round_ctrl.md
# lw_sha_round_ctrl

Sequencer for the lightweight SHA compression loop. It holds the masked working state `a..h`, feeds it to the combinational `lw_sha_round` datapath together with the round index, message word and fresh masking bits, and registers `new_state` back once per accepted word. It runs 64 rounds in SHA-256 mode or 80 rounds in SHA-512 mode. It sits between the message scheduler (word source) and the hash-update stage (final `H += state`). It never unmasks state; all words stay in the `WORD_SIZE+1`-bit masked encoding end to end.

## Interface
- `WORD_SIZE` (macro from defines.v), default 64 under CORE_ARCH_S64 and 32 under CORE_ARCH_S32: unmasked word width. State words are `WORD_SIZE+1` bits.
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `mode_i` input 1: 0 = SHA-256 (64 rounds), 1 = SHA-512 (80 rounds). Sampled at start only. Present only under CORE_ARCH_S64; S32 behaves as constant 0.
- `start_i` input 1: begin a block. Honoured in IDLE only.
- `abort_i` input 1: synchronous cancel; returns to IDLE with no `done_o`.
- `init_state_i` input 8×(`WORD_SIZE`+1): masked initial state, [7]=a … [0]=h. Captured on the accepted start.
- `word_i` input `WORD_SIZE`: schedule word W[t].
- `word_valid_i` input 1: `word_i` is valid.
- `word_ready_o` output 1: the controller consumes `word_i` this cycle when valid.
- `rnd_i` input 2: fresh randomness, forwarded to the datapath `random_i`.
- `rnd_state_o` output 8×(`WORD_SIZE`+1): working state to the datapath `state`.
- `rnd_word_o` output `WORD_SIZE`: equals `word_i` (pass-through).
- `rnd_index_o` output 7: current round index t.
- `rnd_random_o` output 2: equals `rnd_i` while a round fires, otherwise 0.
- `rnd_mode_o` output 1: latched mode.
- `rnd_new_state_i` input 8×(`WORD_SIZE`+1): datapath `new_state`.
- `busy_o` output 1: high in RUN and DONE.
- `done_o` output 1: one-cycle pulse when the final state is available.
- `state_o` output 8×(`WORD_SIZE`+1): final masked state. Valid from `done_o` until the next accepted start.

## Operation
- FSM states are IDLE, RUN and DONE.
  - **IDLE.** On `start_i`=1: load `init_state_i` into the state register, clear the index to 0, latch `mode_i`, go to RUN.
  - **RUN.** `word_ready_o`=1. A round fires when `word_valid_i`=1:
    - the state register takes `rnd_new_state_i`;
    - the index increments.
    - If the fired index equals `last` (63 in mode 0, 79 in mode 1), go to DONE instead of incrementing.
    - With `word_valid_i`=0 (stall), state and index hold.
  - **DONE.** `done_o`=1 for exactly this cycle, `state_o` is driven from the state register, and the FSM goes to IDLE unconditionally.
- `state_o` mirrors the state register. It is stable outside RUN.
- The index is 7 bits and never exceeds `last`; there is no wrap.
- `abort_i` has priority over everything in RUN and DONE. When asserted, the next state is IDLE, `done_o` is not raised, and the state register holds its value.
- `start_i` in RUN or DONE is ignored. `start_i` together with `abort_i` in IDLE: start wins.
- `rnd_i` is consumed only on firing cycles. A new random pair is required per round; the controller does not reuse values.
- Mode is constant from start to done; `mode_i` changes mid-block have no effect.

## Timing
- Reset values:
  - FSM = IDLE, index = 0, mode = 0, state register = all zero;
  - `busy_o`=0, `done_o`=0, `word_ready_o`=0, `rnd_random_o`=0, `state_o`=0.
- Start accepted at edge T. RUN starts at cycle T+1, and the first round can fire at edge T+1.
- With no stalls, the last round fires at edge T+N (N = 64/80), and `done_o` is high in cycle T+N+1. Each stalled cycle adds one cycle.
- Throughput is one round per cycle. The datapath is combinational and is closed in one cycle between `rnd_state_o` and `rnd_new_state_i`.
- Handshake: a transfer happens when `word_valid_i` && `word_ready_o` at a rising edge. `word_ready_o` does not depend on `word_valid_i`.
- Back-to-back blocks: a start is accepted in the cycle after `done_o`, at the earliest.
- Reset asserted mid-RUN: immediately (asynchronously) returns to reset values. No `done_o`.

## Test plan
- **SHA-256 "abc", rnd_i=0, continuous valid.**
  - Stimulus: start with IV 6a09e667…5be0cd19 in masked encoding, mode 0.
  - Required: `done_o` exactly 65 cycles after start. read_word(`state_o[7]`)=506e3058, so that 506e3058+6a09e667 = ba7816bf.
- **Same vector, random `rnd_i` and `word_valid_i` dropped on 30% of cycles.**
  - Required: identical unmasked final state. `done_o` latency = 65 + number of stall cycles. Index holds during stalls.
- **SHA-512 "abc", mode 1 (S64).**
  - Required: 80 fired rounds, and `rnd_index_o` sequence 0..79. Final a + 6a09e667f3bcc908 = ddaf35a193617aba.
- **Abort at round 20.**
  - Required: `busy_o` falls next cycle, no `done_o`, `word_ready_o`=0. A following start completes normally.
- **`rst_ni` pulsed at round 40.**
  - Required: all outputs return to reset values asynchronously.
- **`start_i` held high through an entire block.**
  - Required: second block starts the cycle after `done_o`. `mode_i` toggled mid-block changes neither `rnd_mode_o` nor the round count.
